// File: rtl/seven_segment_pkg.sv
// Shared glyph types and the hex-to-seven-segment decode table for the
// multiplexed display driver.
package seven_segment_pkg;

   typedef logic [6:0] seg_glyph_t;

   // Active-high dark glyph; the driver applies output polarity afterwards
   localparam seg_glyph_t SEG_OFF = 7'b0000000;

   // Bit order is ABCDEFG (seg[6]=A)
   localparam seg_glyph_t HEX_GLYPHS [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   function automatic seg_glyph_t hex_to_seg(input logic [3:0] nibble);
      return HEX_GLYPHS[nibble];
   endfunction

endpackage

// File: rtl/seven_segment_lz.sv
// Combinational visibility mask: a digit is visible unless blanked or part of
// the run of leading zeros (digit 0 always survives suppression).
module seven_segment_lz #(
   parameter int NUM_DIGITS = 4
) (
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic                    lz_suppress,
   output logic [NUM_DIGITS-1:0]   visible
);

   logic leading;

   // Walk from the leftmost digit; the first nonzero nibble or set dp ends the run
   always_comb begin
      leading = lz_suppress;
      visible = ~blank;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         if (leading && (digits[4*i +: 4] == 4'h0) && !dp[i]) begin
            visible[i] = 1'b0;
         end else begin
            leading = 1'b0;
         end
      end
   end

endmodule

// File: rtl/seven_segment_mux.sv
// Time-multiplexed seven-segment driver: counter-based slot timer, frame-latched
// shadow inputs, PWM on-window after a guard interval, registered outputs.
module seven_segment_mux
   import seven_segment_pkg::*;
#(
   parameter int NUM_DIGITS     = 4,
   parameter int SLOT_CYCLES    = 12500,
   parameter int GUARD_CYCLES   = 250,
   parameter int BRIGHT_W       = 4,
   parameter int SEG_ACTIVE_LOW = 0,
   parameter int EN_ACTIVE_LOW  = 1
) (
   input  logic                    clk_50mhz,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] digits,
   input  logic [NUM_DIGITS-1:0]   dp_in,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic                    lz_suppress,
   input  logic [BRIGHT_W-1:0]     brightness,
   output logic [6:0]              seg,
   output logic                    dp,
   output logic [NUM_DIGITS-1:0]   dsen,
   output logic                    frame_start
);

   if (GUARD_CYCLES >= SLOT_CYCLES) begin : g_bad_guard
      $error("seven_segment_mux: GUARD_CYCLES must be less than SLOT_CYCLES");
   end
   if (NUM_DIGITS < 1 || NUM_DIGITS > 8) begin : g_bad_digits
      $error("seven_segment_mux: NUM_DIGITS must be in 1..8");
   end

   localparam int CYC_W  = $clog2(SLOT_CYCLES + 1);
   localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam int ACTIVE = SLOT_CYCLES - GUARD_CYCLES;
   localparam int PROD_W = CYC_W + BRIGHT_W + 1;

   localparam logic [CYC_W-1:0]      CYC_LAST     = CYC_W'(SLOT_CYCLES - 1);
   localparam logic [IDX_W-1:0]      IDX_LAST     = IDX_W'(NUM_DIGITS - 1);
   localparam logic [CYC_W:0]        GUARD_X      = (CYC_W + 1)'(GUARD_CYCLES);
   localparam logic [CYC_W-1:0]      ON_LEN_RESET = CYC_W'(ACTIVE >> BRIGHT_W);
   localparam seg_glyph_t            SEG_IDLE     = (SEG_ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
   localparam logic                  DP_IDLE      = (SEG_ACTIVE_LOW != 0);
   localparam logic [NUM_DIGITS-1:0] EN_IDLE      = (EN_ACTIVE_LOW != 0) ? '1 : '0;

   // Lit-window length: full-width product so max brightness yields the whole post-guard slot
   function automatic logic [CYC_W-1:0] duty_len(input logic [BRIGHT_W-1:0] level);
      logic [PROD_W-1:0] prod;
      prod = PROD_W'(ACTIVE) * (PROD_W'(level) + PROD_W'(1));
      return CYC_W'(prod >> BRIGHT_W);
   endfunction

   logic [CYC_W-1:0]        cyc;
   logic [IDX_W-1:0]        idx;
   logic [4*NUM_DIGITS-1:0] dig_sh;
   logic [NUM_DIGITS-1:0]   dp_sh;
   logic [NUM_DIGITS-1:0]   blank_sh;
   logic                    lz_sh;
   logic [CYC_W-1:0]        on_len_sh;

   logic                    frame_p0;
   logic [4*NUM_DIGITS-1:0] dig_p0;
   logic [NUM_DIGITS-1:0]   dp_p0;
   logic [NUM_DIGITS-1:0]   blank_p0;
   logic                    lz_p0;
   logic [CYC_W-1:0]        on_len_p0;
   logic [NUM_DIGITS-1:0]   vis_p0;
   logic                    lit_p0;
   seg_glyph_t              glyph_p0;
   logic [NUM_DIGITS-1:0]   sel_p0;

   // Stage p0: decode the current (cyc, idx) slot position against the frame's data.
   // The latching cycle already uses the incoming values so a frame never mixes old and new.
   assign frame_p0  = (cyc == '0) && (idx == '0);
   assign dig_p0    = frame_p0 ? digits                 : dig_sh;
   assign dp_p0     = frame_p0 ? dp_in                  : dp_sh;
   assign blank_p0  = frame_p0 ? blank                  : blank_sh;
   assign lz_p0     = frame_p0 ? lz_suppress            : lz_sh;
   assign on_len_p0 = frame_p0 ? duty_len(brightness)   : on_len_sh;

   seven_segment_lz #(
      .NUM_DIGITS (NUM_DIGITS)
   ) u_lz (
      .digits      (dig_p0),
      .dp          (dp_p0),
      .blank       (blank_p0),
      .lz_suppress (lz_p0),
      .visible     (vis_p0)
   );

   assign lit_p0   = ({1'b0, cyc} >= GUARD_X) &&
                     ({1'b0, cyc} < (GUARD_X + {1'b0, on_len_p0})) &&
                     vis_p0[idx];
   assign glyph_p0 = hex_to_seg(dig_p0[4*idx +: 4]);
   assign sel_p0   = lit_p0 ? (NUM_DIGITS'(1) << idx) : '0;

   // Stage p1: slot timer, frame shadows and registered pad outputs
   always_ff @(posedge clk_50mhz) begin
      if (reset) begin
         cyc         <= '0;
         idx         <= '0;
         dig_sh      <= '0;
         dp_sh       <= '0;
         blank_sh    <= '1;
         lz_sh       <= 1'b0;
         on_len_sh   <= ON_LEN_RESET;
         seg         <= SEG_IDLE;
         dp          <= DP_IDLE;
         dsen        <= EN_IDLE;
         frame_start <= 1'b0;
      end else begin
         if (cyc == CYC_LAST) begin
            cyc <= '0;
            idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
         end else begin
            cyc <= cyc + 1'b1;
         end
         if (frame_p0) begin
            dig_sh    <= dig_p0;
            dp_sh     <= dp_p0;
            blank_sh  <= blank_p0;
            lz_sh     <= lz_p0;
            on_len_sh <= on_len_p0;
         end
         seg         <= (lit_p0 ? glyph_p0 : SEG_OFF) ^ SEG_IDLE;
         dp          <= (lit_p0 & dp_p0[idx]) ^ DP_IDLE;
         dsen        <= sel_p0 ^ EN_IDLE;
         frame_start <= frame_p0;
      end
   end

endmodule

// File: tb/tb_seven_segment_mux.sv
// Bench for seven_segment_mux: directed scenarios plus random traffic, every
// cycle compared against a frame-level behavioural model.
module tb_seven_segment_mux;

   localparam int ND = 4;
   localparam int SC = 16;
   localparam int GC = 2;
   localparam int BW = 2;
   localparam int FRAME = ND * SC;

   logic        clk_50mhz = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] digits = '0;
   logic [3:0]  dp_in = '0;
   logic [3:0]  blank = '0;
   logic        lz_suppress = 1'b0;
   logic [1:0]  brightness = '0;
   logic [6:0]  seg;
   logic        dp;
   logic [3:0]  dsen;
   logic        frame_start;

   seven_segment_mux #(
      .NUM_DIGITS     (ND),
      .SLOT_CYCLES    (SC),
      .GUARD_CYCLES   (GC),
      .BRIGHT_W       (BW),
      .SEG_ACTIVE_LOW (0),
      .EN_ACTIVE_LOW  (1)
   ) dut (
      .clk_50mhz   (clk_50mhz),
      .reset       (reset),
      .digits      (digits),
      .dp_in       (dp_in),
      .blank       (blank),
      .lz_suppress (lz_suppress),
      .brightness  (brightness),
      .seg         (seg),
      .dp          (dp),
      .dsen        (dsen),
      .frame_start (frame_start)
   );

   always #10 clk_50mhz = ~clk_50mhz;

   logic [6:0] glyph_tab [16] = '{
      7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
      7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
      7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
      7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
   };

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s got=%0h exp=%0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // Model: frame contents snapshot and position within the frame
   int          k = 0;
   int          last_p = -1;
   logic [15:0] l_dig;
   logic [3:0]  l_dp;
   logic [3:0]  l_blank = 4'hF;
   bit          l_lz;
   int          l_bright;
   logic [6:0]  e_seg;
   logic        e_dp;
   logic [3:0]  e_dsen;
   logic        e_fs;

   // A digit shows if not blanked and, under suppression, something at or left of it is nonzero/dotted
   function automatic bit digit_visible(input int d);
      if (l_blank[d]) return 1'b0;
      if (!l_lz || d == 0) return 1'b1;
      for (int j = d; j < ND; j++)
         if (l_dig[4*j +: 4] != 4'h0 || l_dp[j]) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_edge();
      int p, slot, c, on_len;
      bit lit;
      if (reset) begin
         k = 0; last_p = -1;
         l_dig = '0; l_dp = '0; l_blank = 4'hF; l_lz = 1'b0; l_bright = 0;
         e_seg = 7'b0; e_dp = 1'b0; e_dsen = 4'hF; e_fs = 1'b0;
      end else begin
         p = k % FRAME;
         if (p == 0) begin
            l_dig = digits; l_dp = dp_in; l_blank = blank;
            l_lz = lz_suppress; l_bright = int'(brightness);
         end
         slot   = p / SC;
         c      = p % SC;
         on_len = ((SC - GC) * (l_bright + 1)) / (1 << BW);
         lit    = (c >= GC) && (c < GC + on_len) && digit_visible(slot);
         e_seg  = lit ? glyph_tab[l_dig[4*slot +: 4]] : 7'b0;
         e_dp   = lit && l_dp[slot];
         e_dsen = lit ? ~(4'b0001 << slot) : 4'hF;
         e_fs   = (p == 0);
         last_p = p;
         k++;
      end
   endtask

   task automatic step();
      @(posedge clk_50mhz);
      model_edge();
      #1;
      check_val("seg", 32'(seg), 32'(e_seg));
      check_val("dp", 32'(dp), 32'(e_dp));
      check_val("dsen", 32'(dsen), 32'(e_dsen));
      check_val("frame_start", 32'(frame_start), 32'(e_fs));
   endtask

   task automatic run_to(input int slot, input int c);
      int target;
      target = slot * SC + c;
      for (int i = 0; i < 3 * FRAME; i++) begin
         if (last_p == target) return;
         step();
      end
      check_val("run_to_timeout", 32'(last_p), 32'(target));
   endtask

   task automatic next_frame();
      for (int i = 0; i < 3 * FRAME; i++) begin
         step();
         if (last_p == 0) return;
      end
      check_val("next_frame_timeout", 32'(last_p), 32'd0);
   endtask

   initial begin
      // Reset held for 5 cycles
      reset = 1'b1;
      digits = 16'hABCD; dp_in = 4'hF; brightness = 2'd3;
      for (int i = 0; i < 5; i++) step();
      check_val("rst_seg", 32'(seg), 32'h0);
      check_val("rst_dsen", 32'(dsen), 32'hF);
      check_val("rst_fs", 32'(frame_start), 32'h0);

      // Digits and full brightness
      digits = 16'h4321; dp_in = 4'h0; blank = 4'h0; lz_suppress = 1'b0; brightness = 2'd3;
      reset = 1'b0;
      step();
      check_val("first_fs", 32'(frame_start), 32'h1);
      run_to(0, 1);  check_val("guard_dsen", 32'(dsen), 32'hF);
      run_to(0, 2);  check_val("s0_dsen", 32'(dsen), 32'hE);
      check_val("s0_seg", 32'(seg), 32'b0110000);
      run_to(0, 15); check_val("s0_end_dsen", 32'(dsen), 32'hE);
      run_to(1, 5);  check_val("s1_dsen", 32'(dsen), 32'hD);
      check_val("s1_seg", 32'(seg), 32'b1101101);
      run_to(3, 9);  check_val("s3_dsen", 32'(dsen), 32'h7);
      check_val("s3_seg", 32'(seg), 32'b0110011);

      // Leading-zero suppression
      digits = 16'h0050; lz_suppress = 1'b1;
      next_frame();
      run_to(0, 5);  check_val("lz_d0_seg", 32'(seg), 32'b1111110);
      run_to(1, 5);  check_val("lz_d1_seg", 32'(seg), 32'b1011011);
      run_to(2, 5);  check_val("lz_d2_dsen", 32'(dsen), 32'hF);
      run_to(3, 5);  check_val("lz_d3_dsen", 32'(dsen), 32'hF);
      dp_in = 4'b0100;
      next_frame();
      run_to(2, 5);  check_val("lzdp_d2_seg", 32'(seg), 32'b1111110);
      check_val("lzdp_d2_dp", 32'(dp), 32'h1);
      run_to(3, 5);  check_val("lzdp_d3_dsen", 32'(dsen), 32'hF);

      // Brightness duty
      digits = 16'h4321; dp_in = 4'h0; lz_suppress = 1'b0; brightness = 2'd0;
      next_frame();
      run_to(0, 4);  check_val("b0_last_on", 32'(dsen), 32'hE);
      run_to(0, 5);  check_val("b0_off", 32'(dsen), 32'hF);
      brightness = 2'd1;
      next_frame();
      run_to(0, 8);  check_val("b1_last_on", 32'(dsen), 32'hE);
      run_to(0, 9);  check_val("b1_off", 32'(dsen), 32'hF);

      // Mid-frame change is not visible until the next frame
      digits = 16'h1234; brightness = 2'd3;
      next_frame();
      run_to(2, 3);
      digits = 16'hFFFF;
      run_to(2, 6);  check_val("tear_s2_seg", 32'(seg), 32'b1101101);
      run_to(3, 6);  check_val("tear_s3_seg", 32'(seg), 32'b0110000);
      next_frame();
      run_to(0, 6);  check_val("new_s0_seg", 32'(seg), 32'b1000111);

      // Reset mid-frame
      run_to(2, 5);
      reset = 1'b1;
      step();
      check_val("midrst_dsen", 32'(dsen), 32'hF);
      check_val("midrst_fs", 32'(frame_start), 32'h0);
      reset = 1'b0;
      step();
      check_val("midrst_restart_fs", 32'(frame_start), 32'h1);
      run_to(0, 5);  check_val("midrst_s0_dsen", 32'(dsen), 32'hE);

      // Random traffic, including occasional resets
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 7) == 0) begin
            for (int n = 0; n < ND; n++)
               digits[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            dp_in       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            blank       = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0;
            lz_suppress = 1'($urandom);
            brightness  = 2'($urandom);
         end
         reset = ($urandom_range(0, 499) == 0);
         step();
      end
      reset = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/seven_segment_mux.md
Name: seven_segment_mux

Overview:
Parametrised, time-multiplexed driver for a common-anode/cathode multi-digit seven-segment display. It is the successor of the fixed 4-digit hex display driver. It generalises digit count, drive polarity and refresh rate, and adds:
- per-digit decimal point and blanking
- leading-zero suppression
- PWM brightness
- anti-ghosting guard interval
- tear-free frame latching of inputs

It runs entirely in the clk_50mhz domain with a counter-based slot timer; no derived clock.

Parameters:
NUM_DIGITS, 4, number of digits scanned (1..8)
SLOT_CYCLES, 12500, clk_50mhz cycles per digit slot (default gives 1 kHz per-digit refresh for 4 digits)
GUARD_CYCLES, 250, all-off cycles at start of each slot (ghost suppression); must be < SLOT_CYCLES
BRIGHT_W, 4, width of brightness input
SEG_ACTIVE_LOW, 0, 1 = segment/dp outputs driven low when lit
EN_ACTIVE_LOW, 1, 1 = digit enables driven low when selected

Ports:
clk_50mhz  in  1  system clock
reset  in  1  synchronous, active-high reset
digits  in  4*NUM_DIGITS  hex nibbles; nibble 0 (bits 3:0) = rightmost digit
dp_in  in  NUM_DIGITS  decimal point per digit
blank  in  NUM_DIGITS  force digit dark
lz_suppress  in  1  enable leading-zero suppression
brightness  in  BRIGHT_W  duty level, 0 = dimmest, max = full
seg  out  7  segments, seg[6]=A … seg[0]=G
dp  out  1  decimal point segment
dsen  out  NUM_DIGITS  digit enables, dsen[0] = rightmost
frame_start  out  1  one-cycle pulse at start of each frame

Behaviour:
- Clock and reset: one clock (clk_50mhz). Reset is synchronous, active-high, and is sampled only on the clk_50mhz rising edge.
- State: slot counter cyc (0..SLOT_CYCLES-1) and digit index idx (0..NUM_DIGITS-1).
  - cyc increments every cycle and wraps to 0.
  - On wrap, idx increments and wraps NUM_DIGITS-1 → 0.
  - Scan order is ascending from rightmost digit 0.
- Frame latch: on every edge where reset=0 and cyc=0 and idx=0, capture digits, dp_in, blank, lz_suppress and brightness into shadow registers. Inputs changing mid-frame have no visible effect until the next frame.
- Active length: at latch time, compute on_len = ((SLOT_CYCLES-GUARD_CYCLES)*(brightness+1)) >> BRIGHT_W.
  - Use full-width intermediate; no overflow.
  - brightness = max gives the full post-guard slot.
- Lit condition: digit idx is lit when GUARD_CYCLES <= cyc < GUARD_CYCLES+on_len, and it is neither blanked nor suppressed. When lit, dsen[idx] is active, all other dsen are inactive, and seg/dp carry the glyph. At every other time, all dsen, seg and dp are at the inactive level.
- Leading-zero suppression: applies when the latched lz_suppress=1.
  - Scanning from digit NUM_DIGITS-1 downward, digits are suppressed while nibble=0 and dp=0.
  - Suppression stops at the first nonzero nibble or set dp.
  - Digit 0 is never suppressed.
- Glyphs: hex 0–F, active-high ABCDEFG codes:
  - 0=1111110, 1=0110000, 2=1101101, 3=1111001, 4=0110011, 5=1011011, 6=1011111, 7=1110000
  - 8=1111111, 9=1111011, A=1110111, b=0011111, C=1001110, d=0111101, E=1001111, F=1000111
  - Invert when SEG_ACTIVE_LOW=1.
- Latency: all outputs are registered with one cycle of latency from the (cyc, idx) state.
  - frame_start is high exactly in the output cycle corresponding to cyc=0, idx=0.
  - Frame period = NUM_DIGITS*SLOT_CYCLES.
- Reset behaviour:
  - Reset state: cyc=0, idx=0, shadows cleared (brightness shadow = 0, blank shadow = all ones).
  - Outputs on the next cycle: seg/dp inactive, dsen all inactive, frame_start=0.
  - Reset asserted mid-slot takes effect on that edge. No partial slot continues.
  - The first frame_start appears one cycle after the first non-reset edge.
- Elaboration-time assertions: GUARD_CYCLES < SLOT_CYCLES, 1 <= NUM_DIGITS <= 8.

Decomposition:
- Package seven_segment_pkg:
  - seg_glyph_t (7-bit)
  - hex glyph constant array
  - SEG_OFF constant
  - function hex_to_seg
- Sub-module seven_segment_lz: combinational leading-zero/blank mask generator (digits, dp, blank, lz_suppress → visible mask).
- The top level holds the timer, shadows and output registers.

Test Plan:
All scenarios use NUM_DIGITS=4, SLOT_CYCLES=16, GUARD_CYCLES=2, BRIGHT_W=2, default polarities.
1. Reset: hold reset 5 cycles → seg=0000000, dp=0, dsen=1111, frame_start=0. Release → frame_start pulses 1 cycle after, then every 64 cycles.
2. Digits and brightness: digits=16'h4321, brightness=3, lz off →
   - slot0: dsen=1110 for slot cycles 2..15, seg=0110000
   - slot1: dsen=1101, seg=1101101
   - slot3: dsen=0111, seg=0110011
   - cycles 0..1 of each slot are all off
3. Leading-zero suppression: lz_suppress=1.
   - digits=16'h0050 → digits 3,2 never enabled; digit1 seg=1011011; digit0 seg=1111110.
   - Same with dp_in=4'b0100 → digit2 shows 1111110 with dp=1.
4. Brightness duty: brightness=0 → dsen active for slot cycles 2..4 (on_len=3). brightness=1 → cycles 2..8 (on_len=7).
5. Mid-frame change: change digits to 16'hFFFF during slot 2 → slots 2,3 still show the old values. The new 1000111 glyphs start only after the next frame_start.
6. Reset mid-frame: assert reset for 1 cycle during slot 2 → outputs inactive next cycle. Scanning restarts at digit 0 with frame_start.
